// File: rtl/vram_slot_sched.sv
// Slot scheduler for the slow VRAM port: a repeating slot map shares SRAM
// bandwidth between NCH read-only video channels and one CPU read/write channel.
module vram_slot_sched #(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned NCH       = 3,
  parameter int unsigned SLOT_CLKS = 4,
  parameter int unsigned NSLOT     = 8,
  parameter logic [NSLOT*$clog2(NCH+1)-1:0] SLOT_MAP = 16'hE4E4
) (
  input  logic                      CLK_24M,
  input  logic                      RESETP,
  input  logic [NCH*ADDR_W-1:0]     CH_ADDR,
  output logic [NCH*DATA_W-1:0]     CH_DATA,
  output logic [NCH-1:0]            CH_VALID,
  input  logic                      CPU_REQ,
  input  logic                      CPU_WR,
  input  logic [ADDR_W-1:0]         CPU_ADDR,
  input  logic [DATA_W-1:0]         CPU_WDATA,
  output logic                      CPU_ACK,
  output logic [DATA_W-1:0]         CPU_RDATA,
  output logic [ADDR_W-1:0]         SVRAM_ADDR,
  input  logic [DATA_W-1:0]         SVRAM_DATA_IN,
  output logic [DATA_W-1:0]         SVRAM_DATA_OUT,
  output logic                      nOE,
  output logic                      nWE,
  output logic [$clog2(NSLOT)-1:0]  SLOT_IDX,
  output logic [$clog2(SLOT_CLKS)-1:0] SLOT_PHASE
);

  localparam int unsigned SELW = $clog2(NCH + 1);
  localparam int unsigned IDXW = $clog2(NSLOT);
  localparam int unsigned PHW  = $clog2(SLOT_CLKS);

  logic [PHW-1:0]        phase_q, phase_d;
  logic [IDXW-1:0]       slot_q, slot_d, nidx;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     dout_q, dout_d;
  logic                  noe_q, noe_d, nwe_q, nwe_d;
  logic                  armed_q, armed_d, wslot_q, wslot_d;
  logic [SELW-1:0]       owner_q, owner_d, ncode;
  logic [NCH*DATA_W-1:0] chdata_q, chdata_d;
  logic [NCH-1:0]        chvalid_q, chvalid_d;
  logic                  ack_q, ack_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  pend_q, pend_d, pwr_q, pwr_d;
  logic [ADDR_W-1:0]     paddr_q, paddr_d;
  logic [DATA_W-1:0]     pwdata_q, pwdata_d;
  logic                  slot_end, cpu_done;

  always_comb begin
    phase_d   = phase_q;
    slot_d    = slot_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    noe_d     = noe_q;
    nwe_d     = 1'b1;
    armed_d   = armed_q;
    wslot_d   = wslot_q;
    owner_d   = owner_q;
    chdata_d  = chdata_q;
    chvalid_d = '0;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;
    pend_d    = pend_q;
    pwr_d     = pwr_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    cpu_done  = 1'b0;

    slot_end = (phase_q == PHW'(SLOT_CLKS - 1));
    nidx     = (slot_q == IDXW'(NSLOT - 1)) ? '0 : slot_q + 1'b1;
    ncode    = SLOT_MAP[int'(nidx) * int'(SELW) +: SELW];
    phase_d  = slot_end ? '0 : phase_q + 1'b1;

    if (CPU_REQ && !pend_q && !ack_q) begin
      pend_d   = 1'b1;
      pwr_d    = CPU_WR;
      paddr_d  = CPU_ADDR;
      pwdata_d = CPU_WDATA;
    end

    if (slot_end) begin
      slot_d = nidx;
      if (armed_q) begin
        if (owner_q == SELW'(NCH)) begin
          cpu_done = 1'b1;
          ack_d    = 1'b1;
          pend_d   = 1'b0;
          if (!wslot_q) rdata_d = SVRAM_DATA_IN;
        end else begin
          for (int unsigned k = 0; k < NCH; k++) begin
            if (owner_q == SELW'(k)) begin
              chdata_d[k*DATA_W +: DATA_W] = SVRAM_DATA_IN;
              chvalid_d[k] = 1'b1;
            end
          end
        end
      end

      armed_d = 1'b0;
      wslot_d = 1'b0;
      owner_d = ncode;
      addr_d  = '0;
      noe_d   = 1'b1;
      // A transaction finishing on this edge must not re-arm an adjacent CPU slot.
      if (ncode == SELW'(NCH)) begin
        if (pend_q && !cpu_done) begin
          armed_d = 1'b1;
          addr_d  = paddr_q;
          wslot_d = pwr_q;
          noe_d   = pwr_q;
          if (pwr_q) dout_d = pwdata_q;
        end
      end else begin
        for (int unsigned k = 0; k < NCH; k++) begin
          if (ncode == SELW'(k)) begin
            armed_d = 1'b1;
            addr_d  = CH_ADDR[k*ADDR_W +: ADDR_W];
            noe_d   = 1'b0;
          end
        end
      end
    end

    if (wslot_d && (phase_d != '0) && (phase_d <= PHW'(SLOT_CLKS - 2))) nwe_d = 1'b0;
  end

  always_ff @(posedge CLK_24M) begin
    if (RESETP) begin
      phase_q   <= '0;
      slot_q    <= '0;
      addr_q    <= '0;
      dout_q    <= '0;
      noe_q     <= 1'b1;
      nwe_q     <= 1'b1;
      armed_q   <= 1'b0;
      wslot_q   <= 1'b0;
      owner_q   <= '0;
      chdata_q  <= '0;
      chvalid_q <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      pend_q    <= 1'b0;
      pwr_q     <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      phase_q   <= phase_d;
      slot_q    <= slot_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      noe_q     <= noe_d;
      nwe_q     <= nwe_d;
      armed_q   <= armed_d;
      wslot_q   <= wslot_d;
      owner_q   <= owner_d;
      chdata_q  <= chdata_d;
      chvalid_q <= chvalid_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      pend_q    <= pend_d;
      pwr_q     <= pwr_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign CH_DATA        = chdata_q;
  assign CH_VALID       = chvalid_q;
  assign CPU_ACK        = ack_q;
  assign CPU_RDATA      = rdata_q;
  assign SVRAM_ADDR     = addr_q;
  assign SVRAM_DATA_OUT = dout_q;
  assign nOE            = noe_q;
  assign nWE            = nwe_q;
  assign SLOT_IDX       = slot_q;
  assign SLOT_PHASE     = phase_q;

endmodule

// File: tb/tb_vram_slot_sched.sv
// Scoreboard bench for vram_slot_sched: stimulus queues expected strobes and
// pin probes by cycle; a negedge monitor pops and compares them.
module tb_vram_slot_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [44:0] ch_addr;
  logic [47:0] ch_data;
  logic [2:0]  ch_valid;
  logic        cpu_req, cpu_wr, cpu_ack;
  logic [14:0] cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic [14:0] sv_addr;
  logic [15:0] sv_din, sv_dout;
  logic        noe, nwe;
  logic [2:0]  slot_idx;
  logic [1:0]  slot_ph;

  always #5 clk = ~clk;

  // SRAM model: read data is the address xor a fixed pattern
  assign sv_din = {1'b0, sv_addr} ^ 16'hA5A5;

  vram_slot_sched #(
    .ADDR_W(15), .DATA_W(16), .NCH(3), .SLOT_CLKS(4), .NSLOT(8), .SLOT_MAP(16'hE4E4)
  ) dut (
    .CLK_24M(clk), .RESETP(rst), .CH_ADDR(ch_addr), .CH_DATA(ch_data), .CH_VALID(ch_valid),
    .CPU_REQ(cpu_req), .CPU_WR(cpu_wr), .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wdata),
    .CPU_ACK(cpu_ack), .CPU_RDATA(cpu_rdata), .SVRAM_ADDR(sv_addr), .SVRAM_DATA_IN(sv_din),
    .SVRAM_DATA_OUT(sv_dout), .nOE(noe), .nWE(nwe), .SLOT_IDX(slot_idx), .SLOT_PHASE(slot_ph)
  );

  typedef struct { int cyc; int k; logic [31:0] v; } item_t;
  item_t evq[$];
  item_t pq[$];
  int abs_cyc = 0;
  int base = 0;
  int npass = 0;
  int ntotal = 0;

  localparam int P_IDX = 0, P_PH = 1, P_NOE = 2, P_NWE = 3, P_ADDR = 4, P_DOUT = 5, P_RDATA = 6, P_ACK = 7;
  localparam logic [15:0] D0 = 16'hA5A4, D1 = 16'hD5A5, D2 = 16'hAAAA;

  always @(posedge clk) abs_cyc <= abs_cyc + 1;

  function automatic string pname(input int k);
    case (k)
      P_IDX:   return "slot_idx";
      P_PH:    return "slot_phase";
      P_NOE:   return "nOE";
      P_NWE:   return "nWE";
      P_ADDR:  return "svram_addr";
      P_DOUT:  return "svram_data_out";
      P_RDATA: return "cpu_rdata";
      default: return "cpu_ack";
    endcase
  endfunction

  function automatic logic [31:0] sample(input int k);
    case (k)
      P_IDX:   return {29'd0, slot_idx};
      P_PH:    return {30'd0, slot_ph};
      P_NOE:   return {31'd0, noe};
      P_NWE:   return {31'd0, nwe};
      P_ADDR:  return {17'd0, sv_addr};
      P_DOUT:  return {16'd0, sv_dout};
      P_RDATA: return {16'd0, cpu_rdata};
      default: return {31'd0, cpu_ack};
    endcase
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s at cycle %0d: got %h required %h", name, abs_cyc - base, act, exp);
  endfunction

  function automatic void miss(input string name, input int c);
    ntotal++;
    $display("FAIL %s missing at cycle %0d: got no event required one", name, c - base);
  endfunction

  function automatic void push_ev(input int c, input int k, input logic [15:0] d);
    item_t e;
    int i = 0;
    e.cyc = base + c; e.k = k; e.v = {16'd0, d};
    while (i < evq.size() && evq[i].cyc <= e.cyc) i++;
    evq.insert(i, e);
  endfunction

  function automatic void probe(input int c, input int k, input logic [31:0] v);
    item_t e;
    int i = 0;
    e.cyc = base + c; e.k = k; e.v = v;
    while (i < pq.size() && pq[i].cyc <= e.cyc) i++;
    pq.insert(i, e);
  endfunction

  // ch0 idle in the very first slot 0, then every 16 cycles per channel
  function automatic void push_video(input int off, input int n);
    for (int c = 4; c < n; c += 4) begin
      if (c % 16 == 4 && c > 4) push_ev(off + c, 0, D0);
      else if (c % 16 == 8)     push_ev(off + c, 1, D1);
      else if (c % 16 == 12)    push_ev(off + c, 2, D2);
    end
  endfunction

  always @(negedge clk) begin
    item_t it;
    logic [15:0] obs;
    while (pq.size() > 0 && pq[0].cyc <= abs_cyc) begin
      it = pq.pop_front();
      if (it.cyc < abs_cyc) miss(pname(it.k), it.cyc);
      else chk(pname(it.k), sample(it.k), it.v);
    end
    while (evq.size() > 0 && evq[0].cyc < abs_cyc) begin
      it = evq.pop_front();
      miss("strobe", it.cyc);
    end
    if (cpu_ack || (ch_valid != 3'b000)) begin
      if (evq.size() > 0 && evq[0].cyc == abs_cyc) begin
        it = evq.pop_front();
        obs = (it.k == 3) ? cpu_rdata : ch_data[it.k*16 +: 16];
        chk("strobe_vec", {28'd0, cpu_ack, ch_valid}, (it.k == 3) ? 32'd8 : (32'd1 << it.k));
        chk((it.k == 3) ? "cpu_rdata_ack" : "ch_data", {16'd0, obs}, it.v);
      end else begin
        ntotal++;
        $display("FAIL unexpected_strobe at cycle %0d: got ack=%b valid=%b required none",
                 abs_cyc - base, cpu_ack, ch_valid);
      end
    end
  end

  task automatic flush();
    while (evq.size() > 0) begin item_t it = evq.pop_front(); miss("strobe", it.cyc); end
    while (pq.size() > 0) begin item_t it = pq.pop_front(); miss(pname(it.k), it.cyc); end
  endtask

  task automatic goto(input int n);
    while (abs_cyc < base + n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 40 && !cpu_ack; i++) begin @(posedge clk); #1; end
  endtask

  task automatic release_reset();
    flush();
    rst = 1'b1;
    cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    base = abs_cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    ch_addr = {15'h0F0F, 15'h7000, 15'h0001};
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    // Schedule and video reads, no CPU traffic
    release_reset();
    probe(0, P_IDX, 0); probe(0, P_PH, 0); probe(0, P_NOE, 1); probe(0, P_NWE, 1);
    probe(0, P_ADDR, 0); probe(0, P_DOUT, 0); probe(0, P_RDATA, 0); probe(0, P_ACK, 0);
    probe(3, P_IDX, 0); probe(3, P_PH, 3); probe(3, P_NOE, 1);
    probe(4, P_IDX, 1); probe(4, P_PH, 0); probe(4, P_NOE, 0); probe(4, P_ADDR, 32'h7000);
    probe(12, P_IDX, 3); probe(12, P_NOE, 1); probe(12, P_ADDR, 0);
    probe(20, P_IDX, 5); probe(20, P_ADDR, 32'h7000); probe(20, P_NOE, 0);
    probe(32, P_IDX, 0); probe(32, P_ADDR, 32'h0001); probe(32, P_NOE, 0);
    push_video(0, 42);
    goto(42);

    // CPU write, inputs changed after capture
    release_reset();
    push_video(0, 26);
    push_ev(16, 3, 16'h0000);
    probe(12, P_ADDR, 32'h1234); probe(12, P_NOE, 1); probe(12, P_NWE, 1); probe(12, P_DOUT, 32'hBEEF);
    probe(13, P_NWE, 0); probe(14, P_NWE, 0); probe(14, P_NOE, 1);
    probe(15, P_NWE, 1); probe(15, P_ADDR, 32'h1234);
    probe(16, P_NWE, 1); probe(16, P_NOE, 0); probe(16, P_ADDR, 32'h0001);
    probe(17, P_ACK, 0); probe(17, P_RDATA, 0);
    goto(1);
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 15'h1234; cpu_wdata = 16'hBEEF;
    goto(3);
    cpu_addr = 15'h0555; cpu_wdata = 16'h1111;
    wait_ack();
    cpu_req = 1'b0;
    goto(26);

    // CPU read captured on the arming edge of slot 3
    release_reset();
    push_video(0, 34);
    push_ev(32, 3, 16'hB791);
    probe(12, P_NOE, 1); probe(12, P_ADDR, 0);
    probe(28, P_ADDR, 32'h1234); probe(28, P_NOE, 0); probe(28, P_NWE, 1);
    probe(33, P_RDATA, 32'hB791); probe(33, P_ACK, 0);
    goto(11);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 15'h1234;
    wait_ack();
    cpu_req = 1'b0;
    goto(34);

    // Request held high: one read per CPU slot
    release_reset();
    push_video(0, 42);
    push_ev(16, 3, 16'h8787);
    push_ev(32, 3, 16'h8787);
    probe(17, P_ACK, 0); probe(24, P_RDATA, 32'h8787);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 15'h2222;
    goto(40);
    cpu_req = 1'b0;
    goto(42);

    // Reset in the middle of a write slot
    release_reset();
    push_video(0, 14);
    push_video(14, 26);
    probe(12, P_NWE, 1); probe(12, P_DOUT, 32'hBEEF);
    probe(13, P_NWE, 0); probe(13, P_ADDR, 32'h1234);
    probe(14, P_NWE, 1); probe(14, P_NOE, 1); probe(14, P_IDX, 0); probe(14, P_PH, 0);
    probe(14, P_ADDR, 0); probe(14, P_DOUT, 0);
    probe(16, P_ACK, 0);
    probe(26, P_NOE, 1); probe(26, P_ADDR, 0); probe(26, P_NWE, 1);
    goto(1);
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 15'h1234; cpu_wdata = 16'hBEEF;
    goto(13);
    rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    goto(40);

    flush();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/vram_slot_sched.md
# vram_slot_sched

Parametrised slot scheduler for the slow (120 ns) VRAM port of the LSPC video path. A fixed, repeating slot map divides external SRAM bandwidth between NCH read-only video fetch channels (fix map, sprite map even/odd, and similar) and one CPU read/write channel. The CPU channel uses a request/acknowledge handshake. It replaces hard-wired per-purpose address muxing and latch strobes with a configurable slot length, slot count and channel map.

## Interface
- ADDR_W, 15, VRAM address width
- DATA_W, 16, VRAM data width
- NCH, 3, number of video read channels (1..7)
- SLOT_CLKS, 4, clocks per slot (>= 3)
- NSLOT, 8, slots per schedule period (>= 2)
- SLOT_MAP, 16'hE4E4, owner code per slot, slot i at bits [i*SELW +: SELW]
  - SELW = clog2(NCH+1), derived localparam.
  - Code 0..NCH-1 selects a video channel, code NCH is the CPU, any other code is idle.
  - The default gives slot0=ch0, slot1=ch1, slot2=ch2, slot3=CPU, then repeats.

Ports:
- CLK_24M  in  1  sole clock
- RESETP  in  1  reset, synchronous, active-high
- CH_ADDR  in  NCH*ADDR_W  per-channel fetch address, channel k at [k*ADDR_W +: ADDR_W]
- CH_DATA  out  NCH*DATA_W  per-channel latched read data
- CH_VALID  out  NCH  one-clock strobe, high when CH_DATA[k] has just been updated
- CPU_REQ  in  1  CPU transaction request (level)
- CPU_WR  in  1  1 = write, 0 = read; sampled with CPU_REQ
- CPU_ADDR  in  ADDR_W  CPU address
- CPU_WDATA  in  DATA_W  CPU write data
- CPU_ACK  out  1  one-clock completion strobe
- CPU_RDATA  out  DATA_W  CPU read data, valid from the CPU_ACK cycle and held
- SVRAM_ADDR  out  ADDR_W  SRAM address (registered)
- SVRAM_DATA_IN  in  DATA_W  SRAM read data
- SVRAM_DATA_OUT  out  DATA_W  SRAM write data
- nOE  out  1  SRAM output enable, active-low
- nWE  out  1  SRAM write enable, active-low
- SLOT_IDX  out  clog2(NSLOT)  current slot
- SLOT_PHASE  out  clog2(SLOT_CLKS)  clock within the slot

## Operation
**Counters**
- SLOT_PHASE counts 0..SLOT_CLKS-1 and wraps.
- SLOT_IDX increments on the phase wrap and wraps from NSLOT-1 to 0.
- The "slot-end edge" is the clock edge on which SLOT_PHASE = SLOT_CLKS-1.

**Arming (on each slot-end edge, for the next slot's owner)**
- Video channel k: SVRAM_ADDR <= CH_ADDR[k]. nOE is low for the whole next slot and nWE stays high.
- CPU owner with pending=1: SVRAM_ADDR <= the captured CPU address.
  - Read: nOE is low for the whole slot.
  - Write: nOE is high for the whole slot, SVRAM_DATA_OUT = captured data, and nWE is low in phases 1..SLOT_CLKS-2 only.
- CPU owner with pending=0, or an idle code: SVRAM_ADDR <= 0, nOE=1, nWE=1, no strobe.
- The arming decision uses the pending value from before the edge.

**Completion (on the slot-end edge of an armed slot)**
- Video slot: CH_DATA[owner] <= SVRAM_DATA_IN, and CH_VALID[owner] is high for the next clock.
- CPU read: CPU_RDATA <= SVRAM_DATA_IN, CPU_ACK pulses for the next clock, pending is cleared.
- CPU write: CPU_ACK pulses for the next clock, pending is cleared, CPU_RDATA holds its value.

**CPU capture**
- On any edge with CPU_REQ=1, pending=0 and CPU_ACK=0: latch CPU_WR, CPU_ADDR and CPU_WDATA, and set pending.
- The CPU may change its inputs after capture.
- A CPU_REQ held high produces back-to-back transactions, at most one per CPU slot.

**Slot 0 after reset**
- Slot 0 is idle (no arming took place): nOE=1, no strobe.

## Timing
- Reset values: SLOT_IDX=0, SLOT_PHASE=0, SVRAM_ADDR=0, SVRAM_DATA_OUT=0, nOE=1, nWE=1, all CH_DATA=0, CH_VALID=0, CPU_ACK=0, CPU_RDATA=0, pending=0.
- Reset mid-operation:
  - All state reaches its reset value on the first edge with RESETP=1.
  - An in-flight CPU transaction is dropped with no CPU_ACK.
  - An in-progress write is cut: nWE=1 from the next cycle.
- Cycle 0 is the first cycle with RESETP=0, at phase 0 of slot 0.
- Video channel latency: the address is sampled one clock before the slot starts; data is valid one clock after the slot ends.
- CPU latency:
  - Capture takes 1 edge.
  - The CPU then waits for the next CPU slot whose arming edge comes after the capture.
  - CPU_ACK follows at phase 0 of the slot after the CPU slot.
- Simultaneous events:
  - A capture on an arming edge misses that CPU slot.
  - CH_VALID bits are mutually exclusive, and are never high together with CPU_ACK.
- SVRAM_ADDR, nOE and nWE change only at slot boundaries, except the nWE pulse inside a write slot.

## Test plan
- **Schedule:** release reset with default parameters.
  - SLOT_IDX advances every 4 clocks; slot 0 has nOE=1.
  - CH_VALID[1] pulses at cycle 8 and CH_VALID[2] at cycle 12.
  - CH_VALID[0] first pulses at cycle 20; CPU_ACK stays 0 with no request.
- **Video read:** memory model returns addr^16'hA5A5, CH_ADDR[1]=15'h7000 -> SVRAM_ADDR=7000 during slot 1 and slot 5, CH_DATA[1]=16'hD5A5 with CH_VALID[1] at cycles 8 and 24.
- **CPU write:** CPU_REQ, CPU_WR=1, addr 15'h1234, data 16'hBEEF, raised at cycle 1 and dropped at CPU_ACK.
  - Slot 3: SVRAM_ADDR=1234, nOE=1, nWE low at cycles 13-14, SVRAM_DATA_OUT=BEEF.
  - CPU_ACK at cycle 16 only.
- **CPU read on the arming edge:** read of 15'h1234 raised at cycle 11 -> slot 3 idle, served in slot 7, CPU_ACK at cycle 32, CPU_RDATA=16'hB791.
- **Held request:** CPU_REQ held high for 40 cycles -> CPU_ACK at cycles 16 and 32 only, one transaction per CPU slot.
- **Reset during write:** RESETP=1 at cycle 13 of the write scenario -> from cycle 14, nWE=1, nOE=1, SLOT_IDX=0, pending cleared; no CPU_ACK ever issued for that write.
